// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed seven-segment scan driver. A new value is staged in
// a pending register and swapped into the display register only at frame end.
module seg_scan_driver #(
   parameter int unsigned SCAN_DIV = 50000,
   parameter int unsigned CNT_W    = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [31:0] data_in,
   input  logic [7:0]  dp_in,
   input  logic        load,
   input  logic        lz_en,
   output logic [3:0]  digit_nibble,
   output logic [7:0]  digit_sel,
   output logic        dp_out,
   output logic        frame_done
);

   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [31:0]      disp_val_q, disp_val_d;
   logic [7:0]       disp_dp_q, disp_dp_d;
   logic [31:0]      pend_val_q, pend_val_d;
   logic [7:0]       pend_dp_q, pend_dp_d;
   logic             pend_valid_q, pend_valid_d;
   logic             frame_done_q, frame_done_d;

   logic             tick_s;
   logic             frame_end_s;
   logic             commit_s;
   logic [31:0]      shifted_s;
   logic             blank_s;

   // Next-state logic: divider, digit index, pending/display registers.
   always_comb begin
      tick_s      = enable && (div_cnt_q == DIV_LAST);
      frame_end_s = tick_s && (idx_q == 3'd7);
      commit_s    = frame_end_s && pend_valid_q;

      div_cnt_d    = div_cnt_q;
      idx_d        = idx_q;
      disp_val_d   = disp_val_q;
      disp_dp_d    = disp_dp_q;
      pend_val_d   = pend_val_q;
      pend_dp_d    = pend_dp_q;
      pend_valid_d = pend_valid_q;
      frame_done_d = frame_end_s;

      if (!enable) begin
         div_cnt_d = div_cnt_q;
         idx_d     = idx_q;
      end else if (tick_s) begin
         div_cnt_d = {CNT_W{1'b0}};
         idx_d     = idx_q + 3'd1;
      end else begin
         div_cnt_d = div_cnt_q + CNT_W'(1);
         idx_d     = idx_q;
      end

      // Commit uses the pre-load pending value; a coincident load stays pending.
      if (commit_s) begin
         disp_val_d = pend_val_q;
         disp_dp_d  = pend_dp_q;
      end else begin
         disp_val_d = disp_val_q;
         disp_dp_d  = disp_dp_q;
      end

      if (load) begin
         pend_val_d   = data_in;
         pend_dp_d    = dp_in;
         pend_valid_d = 1'b1;
      end else if (commit_s) begin
         pend_valid_d = 1'b0;
      end else begin
         pend_valid_d = pend_valid_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt_q    <= {CNT_W{1'b0}};
         idx_q        <= 3'd0;
         disp_val_q   <= 32'd0;
         disp_dp_q    <= 8'd0;
         pend_val_q   <= 32'd0;
         pend_dp_q    <= 8'd0;
         pend_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         div_cnt_q    <= div_cnt_d;
         idx_q        <= idx_d;
         disp_val_q   <= disp_val_d;
         disp_dp_q    <= disp_dp_d;
         pend_val_q   <= pend_val_d;
         pend_dp_q    <= pend_dp_d;
         pend_valid_q <= pend_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Output decode from registered state; digit 0 is never blanked.
   always_comb begin
      shifted_s    = disp_val_q >> {idx_q, 2'b00};
      digit_nibble = shifted_s[3:0];
      blank_s      = lz_en && (idx_q != 3'd0) && (shifted_s == 32'd0);
      if (!enable || blank_s) begin
         digit_sel = 8'hFF;
         dp_out    = 1'b1;
      end else begin
         digit_sel = ~(8'h01 << idx_q);
         dp_out    = ~disp_dp_q[idx_q];
      end
   end

   assign frame_done = frame_done_q;

endmodule
